// File: rtl/word_serializer_if.sv
// Parallel-load handshake and serial bit-stream bundle for word_serializer.
interface word_serializer_if #(parameter int SIZE = 2);
  logic            start;
  logic [SIZE-1:0] inData;
  logic            inTag;
  logic            ready;
  logic            busy;
  logic            serOut;
  logic            serValid;
  logic            serFirst;
  logic            serLast;
  logic            serReady;
  logic            done;

  modport master (
    output start, inData, inTag, serReady,
    input  ready, busy, serOut, serValid, serFirst, serLast, done
  );

  modport slave (
    input  start, inData, inTag, serReady,
    output ready, busy, serOut, serValid, serFirst, serLast, done
  );
endinterface

// File: rtl/word_serializer.sv
// Serializes a tagged parallel word onto a stallable 1-bit link: tag first, then data LSB first.
module word_serializer #(
  parameter int SIZE = 2
) (
  input  logic             clk,
  input  logic             rst,
  word_serializer_if.slave bus
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [1:0]    IDLE     = 2'd0;
  localparam logic [1:0]    SEND     = 2'd1;
  localparam logic [1:0]    DONE     = 2'd2;
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE);

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic            tag_q, tag_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.inData;
          tag_d   = bus.inTag;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.serReady) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
            // The tag slot does not consume a data bit, so only shift after it.
            if (cnt_q != '0) shift_d = shift_q >> 1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      tag_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is a decode of registered state only.
  assign bus.ready    = (state_q == IDLE);
  assign bus.busy     = (state_q == SEND) || (state_q == DONE);
  assign bus.serValid = (state_q == SEND);
  assign bus.serFirst = (state_q == SEND) && (cnt_q == '0);
  assign bus.serLast  = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign bus.serOut   = (state_q == SEND) ? ((cnt_q == '0) ? tag_q : shift_q[0]) : 1'b0;
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer at SIZE = 1, 2 and 8.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_serializer_if #(.SIZE(1)) s1 ();
  word_serializer_if #(.SIZE(2)) s2 ();
  word_serializer_if #(.SIZE(8)) s8 ();

  word_serializer #(.SIZE(1)) dut1 (.clk(clk), .rst(rst), .bus(s1.slave));
  word_serializer #(.SIZE(2)) dut2 (.clk(clk), .rst(rst), .bus(s2.slave));
  word_serializer #(.SIZE(8)) dut8 (.clk(clk), .rst(rst), .bus(s8.slave));

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } bit_t;

  bit_t q1[$];
  bit_t q2[$];
  bit_t q8[$];
  int   vec  = 0;
  int   errs = 0;

  // Expected frame: tag, then data LSB first; first flag on tag, last flag on data MSB.
  function automatic void push_frame(int size, logic tag, logic [7:0] data);
    for (int k = 0; k <= size; k++) begin
      bit_t e;
      if (k == 0) e.b = tag;
      else        e.b = data[k-1];
      e.f = (k == 0);
      e.l = (k == size);
      case (size)
        1:       q1.push_back(e);
        2:       q2.push_back(e);
        default: q8.push_back(e);
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec++;
    if ({s2.ready, s2.busy, s2.serOut, s2.serValid, s2.serFirst, s2.serLast, s2.done} !== 7'b1000000) begin
      errs++;
      $display("FAIL reset_hold got %b exp 1000000",
               {s2.ready, s2.busy, s2.serOut, s2.serValid, s2.serFirst, s2.serLast, s2.done});
    end
    rst = 1'b0;
    s2.inData = 2'b10; s2.inTag = 1'b1; s2.serReady = 1'b1; s2.start = 1'b1;
    tick();
    s2.start = 1'b0;
    vec++;
    if ({s2.serValid, s2.serOut, s2.serFirst} !== 3'b111) begin
      errs++;
      $display("FAIL reset_pre got %b exp 111", {s2.serValid, s2.serOut, s2.serFirst});
    end
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({s2.ready, s2.busy, s2.serOut, s2.serValid, s2.serFirst, s2.serLast, s2.done} !== 7'b1000000) begin
      errs++;
      $display("FAIL reset_async got %b exp 1000000",
               {s2.ready, s2.busy, s2.serOut, s2.serValid, s2.serFirst, s2.serLast, s2.done});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_st;
    q2.delete();
    push_frame(2, 1'b1, 8'h02);
    s2.inData = 2'b10; s2.inTag = 1'b1; s2.serReady = 1'b1; s2.start = 1'b1;
    tick();
    s2.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp_st = {c >= 5, c <= 4, c <= 3, c == 4};
      vec++;
      if ({s2.ready, s2.busy, s2.serValid, s2.done} !== exp_st) begin
        errs++;
        $display("FAIL basic_status c=%0d got %b exp %b", c, {s2.ready, s2.busy, s2.serValid, s2.done}, exp_st);
      end
      if (s2.serValid) begin
        vec++;
        if (q2.size() == 0) begin
          errs++;
          $display("FAIL basic_extra_bit c=%0d got %b exp none", c, s2.serOut);
        end else if ({s2.serOut, s2.serFirst, s2.serLast} !== q2[0]) begin
          errs++;
          $display("FAIL basic_bit c=%0d got %b exp %b", c, {s2.serOut, s2.serFirst, s2.serLast}, q2[0]);
        end
        if (s2.serReady && q2.size() != 0) void'(q2.pop_front());
      end
      tick();
    end
    vec++;
    if (q2.size() != 0) begin
      errs++;
      $display("FAIL basic_missing got %0d exp 0 bits left", q2.size());
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_st;
    q2.delete();
    push_frame(2, 1'b1, 8'h02);
    s2.inData = 2'b10; s2.inTag = 1'b1; s2.serReady = 1'b1; s2.start = 1'b1;
    tick();
    s2.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      s2.serReady = !(c >= 2 && c <= 4);
      exp_st = {c >= 8, c <= 7, c <= 6, c == 7};
      vec++;
      if ({s2.ready, s2.busy, s2.serValid, s2.done} !== exp_st) begin
        errs++;
        $display("FAIL stall_status c=%0d got %b exp %b", c, {s2.ready, s2.busy, s2.serValid, s2.done}, exp_st);
      end
      if (s2.serValid) begin
        vec++;
        if (q2.size() == 0) begin
          errs++;
          $display("FAIL stall_extra_bit c=%0d got %b exp none", c, s2.serOut);
        end else if ({s2.serOut, s2.serFirst, s2.serLast} !== q2[0]) begin
          errs++;
          $display("FAIL stall_bit c=%0d got %b exp %b", c, {s2.serOut, s2.serFirst, s2.serLast}, q2[0]);
        end
        if (s2.serReady && q2.size() != 0) void'(q2.pop_front());
      end
      tick();
    end
    s2.serReady = 1'b1;
    vec++;
    if (q2.size() != 0) begin
      errs++;
      $display("FAIL stall_missing got %0d exp 0 bits left", q2.size());
    end
  endtask

  task automatic test_ignored_start();
    logic [3:0] exp_st;
    q2.delete();
    push_frame(2, 1'b0, 8'h02);
    s2.inData = 2'b10; s2.inTag = 1'b0; s2.serReady = 1'b1; s2.start = 1'b1;
    tick();
    s2.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_st = {c >= 5, c <= 4, c <= 3, c == 4};
      vec++;
      if ({s2.ready, s2.busy, s2.serValid, s2.done} !== exp_st) begin
        errs++;
        $display("FAIL ignstart_status c=%0d got %b exp %b", c, {s2.ready, s2.busy, s2.serValid, s2.done}, exp_st);
      end
      if (s2.serValid) begin
        vec++;
        if (q2.size() == 0) begin
          errs++;
          $display("FAIL ignstart_extra_bit c=%0d got %b exp none", c, s2.serOut);
        end else if ({s2.serOut, s2.serFirst, s2.serLast} !== q2[0]) begin
          errs++;
          $display("FAIL ignstart_bit c=%0d got %b exp %b", c, {s2.serOut, s2.serFirst, s2.serLast}, q2[0]);
        end
        if (s2.serReady && q2.size() != 0) void'(q2.pop_front());
      end
      s2.start  = (c == 2 || c == 4);
      s2.inData = 2'b01;
      s2.inTag  = 1'b1;
      tick();
    end
    s2.start = 1'b0;
    vec++;
    if (q2.size() != 0) begin
      errs++;
      $display("FAIL ignstart_missing got %0d exp 0 bits left", q2.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp_st;
    q2.delete();
    s2.inData = 2'b01; s2.inTag = 1'b1; s2.serReady = 1'b1; s2.start = 1'b1;
    tick();
    s2.start = 1'b0;
    tick();
    vec++;
    if ({s2.serValid, s2.serOut, s2.serFirst} !== 3'b110) begin
      errs++;
      $display("FAIL rmf_pre got %b exp 110", {s2.serValid, s2.serOut, s2.serFirst});
    end
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({s2.ready, s2.busy, s2.serValid, s2.done} !== 4'b1000) begin
      errs++;
      $display("FAIL rmf_async got %b exp 1000", {s2.ready, s2.busy, s2.serValid, s2.done});
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vec++;
      if ({s2.ready, s2.busy, s2.serValid, s2.done} !== 4'b1000) begin
        errs++;
        $display("FAIL rmf_quiet c=%0d got %b exp 1000", c, {s2.ready, s2.busy, s2.serValid, s2.done});
      end
      tick();
    end
    push_frame(2, 1'b0, 8'h01);
    s2.inData = 2'b01; s2.inTag = 1'b0; s2.start = 1'b1;
    tick();
    s2.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp_st = {c >= 5, c <= 4, c <= 3, c == 4};
      vec++;
      if ({s2.ready, s2.busy, s2.serValid, s2.done} !== exp_st) begin
        errs++;
        $display("FAIL rmf_status c=%0d got %b exp %b", c, {s2.ready, s2.busy, s2.serValid, s2.done}, exp_st);
      end
      if (s2.serValid) begin
        vec++;
        if (q2.size() == 0) begin
          errs++;
          $display("FAIL rmf_extra_bit c=%0d got %b exp none", c, s2.serOut);
        end else if ({s2.serOut, s2.serFirst, s2.serLast} !== q2[0]) begin
          errs++;
          $display("FAIL rmf_bit c=%0d got %b exp %b", c, {s2.serOut, s2.serFirst, s2.serLast}, q2[0]);
        end
        if (s2.serReady && q2.size() != 0) void'(q2.pop_front());
      end
      tick();
    end
    vec++;
    if (q2.size() != 0) begin
      errs++;
      $display("FAIL rmf_missing got %0d exp 0 bits left", q2.size());
    end
  endtask

  task automatic test_size1();
    logic [3:0] exp_st;
    q1.delete();
    push_frame(1, 1'b1, 8'h00);
    s1.inData = 1'b0; s1.inTag = 1'b1; s1.serReady = 1'b1; s1.start = 1'b1;
    tick();
    s1.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp_st = {c >= 4, c <= 3, c <= 2, c == 3};
      vec++;
      if ({s1.ready, s1.busy, s1.serValid, s1.done} !== exp_st) begin
        errs++;
        $display("FAIL size1_status c=%0d got %b exp %b", c, {s1.ready, s1.busy, s1.serValid, s1.done}, exp_st);
      end
      if (s1.serValid) begin
        vec++;
        if (q1.size() == 0) begin
          errs++;
          $display("FAIL size1_extra_bit c=%0d got %b exp none", c, s1.serOut);
        end else if ({s1.serOut, s1.serFirst, s1.serLast} !== q1[0]) begin
          errs++;
          $display("FAIL size1_bit c=%0d got %b exp %b", c, {s1.serOut, s1.serFirst, s1.serLast}, q1[0]);
        end
        if (s1.serReady && q1.size() != 0) void'(q1.pop_front());
      end
      tick();
    end
    vec++;
    if (q1.size() != 0) begin
      errs++;
      $display("FAIL size1_missing got %0d exp 0 bits left", q1.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st;
    q8.delete();
    push_frame(8, 1'b0, 8'hA5);
    s8.inData = 8'hA5; s8.inTag = 1'b0; s8.serReady = 1'b1; s8.start = 1'b1;
    tick();
    s8.start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      exp_st = {c == 11 || c == 22, !(c == 11 || c == 22),
                c <= 9 || (c >= 12 && c <= 20), c == 10 || c == 21};
      vec++;
      if ({s8.ready, s8.busy, s8.serValid, s8.done} !== exp_st) begin
        errs++;
        $display("FAIL b2b_status c=%0d got %b exp %b", c, {s8.ready, s8.busy, s8.serValid, s8.done}, exp_st);
      end
      if (s8.serValid) begin
        vec++;
        if (q8.size() == 0) begin
          errs++;
          $display("FAIL b2b_extra_bit c=%0d got %b exp none", c, s8.serOut);
        end else if ({s8.serOut, s8.serFirst, s8.serLast} !== q8[0]) begin
          errs++;
          $display("FAIL b2b_bit c=%0d got %b exp %b", c, {s8.serOut, s8.serFirst, s8.serLast}, q8[0]);
        end
        if (s8.serReady && q8.size() != 0) void'(q8.pop_front());
      end
      if (c == 11) begin
        push_frame(8, 1'b1, 8'h3C);
        s8.inData = 8'h3C;
        s8.inTag  = 1'b1;
      end
      s8.start = (c == 11);
      tick();
    end
    s8.start = 1'b0;
    vec++;
    if (q8.size() != 0) begin
      errs++;
      $display("FAIL b2b_missing got %0d exp 0 bits left", q8.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    s1.start = 1'b0; s1.inData = '0; s1.inTag = 1'b0; s1.serReady = 1'b1;
    s2.start = 1'b0; s2.inData = '0; s2.inTag = 1'b0; s2.serReady = 1'b1;
    s8.start = 1'b0; s8.inData = '0; s8.inTag = 1'b0; s8.serReady = 1'b1;
    tick();
    tick();
    test_reset();
    test_basic();
    test_stall();
    test_ignored_start();
    test_reset_mid_frame();
    test_size1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart of the datapath's parallel load register.
- Accepts one parallel word plus a 1-bit tag through a start/ready handshake and shifts it out one bit per accepted cycle: tag first, then data LSB first.
- The downstream consumer can stall the stream through a ready input.
- Used to move register contents onto narrow serial links between datapath stages.

Parameters:
SIZE, 2, data word width in bits (SIZE >= 1); each frame is SIZE+1 bits long.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  load request; sampled only when ready=1.
inData  input  SIZE  parallel word captured on an accepted start.
inTag  input  1  tag bit captured with inData.
ready  output  1  high in IDLE; block can accept start.
busy  output  1  high in SEND and DONE.
serOut  output  1  current serial bit.
serValid  output  1  serOut holds a frame bit.
serFirst  output  1  current bit is the tag bit (frame start).
serLast  output  1  current bit is data MSB (frame end).
serReady  input  1  consumer accepts the current bit this cycle.
done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (async, any state):
  - state=IDLE, shift register=0, tag register=0, bit counter=0.
  - Outputs: ready=1, busy=0, serOut=0, serValid=0, serFirst=0, serLast=0, done=0.
  - Reset mid-frame aborts the frame; no done pulse is issued.
- All outputs decode from registered state only; there is no combinational path from any input to any output.
- Bit counter is $clog2(SIZE+1) bits wide and counts 0..SIZE.
- IDLE:
  - ready=1.
  - On start=1 at an edge: capture inTag and inData, clear the counter, go to SEND.
  - start=0: stay in IDLE.
- SEND:
  - serValid=1.
  - Counter=0: serOut=tag and serFirst=1.
  - Counter=k (k>=1): serOut=data[k-1].
  - serLast=1 when counter=SIZE.
  - Edge with serReady=1: the bit is consumed. If counter<SIZE, counter increments; if counter=SIZE, go to DONE.
  - Edge with serReady=0: hold counter, serOut and all flags unchanged (stall, any length).
- DONE:
  - done=1, busy=1, serValid=0, ready=0.
  - Always returns to IDLE on the next edge.
- start is ignored in SEND and DONE; there is no queuing. inData and inTag changes after capture have no effect.
- Timing with serReady held at 1 and start accepted at edge 0:
  - Bits are valid in cycles 1..SIZE+1.
  - done=1 in cycle SIZE+2.
  - ready=1 again in cycle SIZE+3.
  - Minimum frame-to-frame spacing is SIZE+3 cycles.
- SIZE=1: frame is tag then data[0]; serLast=1 on the second bit.
- serFirst and serLast are never both high, since SIZE >= 1.

Test Plan:
- Reset check: assert rst mid-cycle -> all outputs at reset values immediately (before next clk edge); ready=1.
- Basic frame, SIZE=2, serReady=1: inData=2'b10, inTag=1, start pulse ->
  - serOut sequence 1,0,1 in cycles 1-3; serFirst in cycle 1, serLast in cycle 3.
  - done in cycle 4; ready=1 in cycle 5.
- Stall: same frame with serReady=0 during cycles 2-4 -> bit 0 (data[0]) held for 4 cycles with counter frozen; total frame spans 6 cycles; sequence still 1,0,1.
- Ignored start: pulse start with inData=2'b01 while in SEND -> current frame unaffected; no second frame follows.
- Reset mid-frame: rst during bit 1 -> serValid=0 at once, no done pulse; the next start sends a complete new frame.
- SIZE=8 build: inData=8'hA5, inTag=0 -> serOut sequence 0,1,0,1,0,0,1,0,1; done at cycle 10; back-to-back start at cycle 11 accepted.
